// File: rtl/issue_stage.sv
// issue_stage: decode-to-execute pipeline stage with a per-register
// write scoreboard. Stalls decode on RAW/WAW hazards, captures register
// file read data and forwards the control bundle, inserting a bubble on
// every stalled cycle.
// Optional build macro ISSUE_STATS_EN enables the issue/stall counters;
// without it iss_stat_issued/iss_stat_stalls are tied to zero.
module issue_stage #(
    parameter int CTRL_W   = 9,
    parameter int ALU_LAT  = 3,
    parameter int LOAD_LAT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        id_iss_addra,
    input  logic [4:0]        id_iss_addrb,
    input  logic [4:0]        id_iss_regdest,
    input  logic              id_iss_selregdest,
    input  logic              id_iss_writereg,
    input  logic              id_iss_readmem,
    input  logic              id_iss_writemem,
    input  logic              id_iss_writeov,
    input  logic [CTRL_W-1:0] id_iss_ctrl,
    input  logic [31:0]       id_iss_imedext,
    input  logic [31:0]       reg_iss_dataa,
    input  logic [31:0]       reg_iss_datab,
    output logic              iss_stall,
    output logic [CTRL_W-1:0] iss_ex_ctrl,
    output logic              iss_ex_writereg,
    output logic              iss_ex_readmem,
    output logic              iss_ex_writemem,
    output logic              iss_ex_writeov,
    output logic [4:0]        iss_ex_regdest,
    output logic [31:0]       iss_ex_rega,
    output logic [31:0]       iss_ex_regb,
    output logic [31:0]       iss_ex_imedext,
    output logic [31:0]       iss_pending,
    output logic [31:0]       iss_stat_issued,
    output logic [31:0]       iss_stat_stalls
);

    localparam logic [2:0] ALU_LAT_C  = 3'(ALU_LAT);
    localparam logic [2:0] LOAD_LAT_C = 3'(LOAD_LAT);

    // Cycles remaining until each register holds its in-flight result.
    logic [2:0]  r_cnt [32];
    logic [2:0]  w_lat;
    logic        w_hz_a;
    logic        w_hz_b;
    logic        w_hz_w;
    logic        w_mark;
    logic [31:0] w_pending;

    assign w_lat  = id_iss_readmem ? LOAD_LAT_C : ALU_LAT_C;
    assign w_hz_a = (id_iss_addra != 5'd0) && (r_cnt[id_iss_addra] != 3'd0);
    assign w_hz_b = (id_iss_selregdest || id_iss_writemem) &&
                    (id_iss_addrb != 5'd0) && (r_cnt[id_iss_addrb] != 3'd0);
    // WAW: a later writer may not finish before the earlier one; equal is fine.
    assign w_hz_w = id_iss_writereg && (id_iss_regdest != 5'd0) &&
                    (r_cnt[id_iss_regdest] > w_lat);
    assign iss_stall = w_hz_a || w_hz_b || w_hz_w;
    assign w_mark    = !iss_stall && id_iss_writereg && (id_iss_regdest != 5'd0);

    // Busy bitmap derived from the scoreboard counters.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_pending = '0;
        for (int i = 0; i < 32; i++) begin
            w_pending[i] = (r_cnt[i] != 3'd0);
        end
    end
    assign iss_pending = w_pending;

    // Scoreboard: load the issuing destination, otherwise count down to zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: this counter array is control state that gates issue, so it is
            // reset explicitly; a data-only memory would not need to be.
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= 3'd0;
            end
        end else begin
            // NOTE: sequential state always uses non-blocking assignments.
            r_cnt[0] <= 3'd0;
            for (int i = 1; i < 32; i++) begin
                if (w_mark && (id_iss_regdest == 5'(i))) begin
                    r_cnt[i] <= w_lat;
                end else if (r_cnt[i] != 3'd0) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end
        end
    end

    // Execute-side pipeline register; a stall or reset loads a bubble.
    always_ff @(posedge clock) begin
        if (!reset || iss_stall) begin
            iss_ex_ctrl     <= '0;
            iss_ex_writereg <= 1'b0;
            iss_ex_readmem  <= 1'b0;
            iss_ex_writemem <= 1'b0;
            iss_ex_writeov  <= 1'b0;
            iss_ex_regdest  <= 5'd0;
            iss_ex_rega     <= 32'd0;
            iss_ex_regb     <= 32'd0;
            iss_ex_imedext  <= 32'd0;
        end else begin
            iss_ex_ctrl     <= id_iss_ctrl;
            iss_ex_writereg <= id_iss_writereg;
            iss_ex_readmem  <= id_iss_readmem;
            iss_ex_writemem <= id_iss_writemem;
            iss_ex_writeov  <= id_iss_writeov;
            iss_ex_regdest  <= id_iss_regdest;
            iss_ex_rega     <= reg_iss_dataa;
            iss_ex_regb     <= reg_iss_datab;
            iss_ex_imedext  <= id_iss_imedext;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stalls;
    logic        w_useful;

    assign w_useful = id_iss_writereg || id_iss_readmem ||
                      id_iss_writemem || id_iss_writeov;

    // Count issued useful instructions and stall cycles; both wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stat_issued <= 32'd0;
            r_stat_stalls <= 32'd0;
        end else if (iss_stall) begin
            r_stat_stalls <= r_stat_stalls + 32'd1;
        end else if (w_useful) begin
            r_stat_issued <= r_stat_issued + 32'd1;
        end
    end

    assign iss_stat_issued = r_stat_issued;
    assign iss_stat_stalls = r_stat_stalls;
`else
    assign iss_stat_issued = 32'd0;
    assign iss_stat_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: reset, ALU/load RAW, r0, WAW and
// reset-during-stall sequences with hand-computed stall counts.
module tb_issue_stage;

    localparam int CTRL_W = 9;

    logic              clock;
    logic              reset;
    logic [4:0]        id_iss_addra;
    logic [4:0]        id_iss_addrb;
    logic [4:0]        id_iss_regdest;
    logic              id_iss_selregdest;
    logic              id_iss_writereg;
    logic              id_iss_readmem;
    logic              id_iss_writemem;
    logic              id_iss_writeov;
    logic [CTRL_W-1:0] id_iss_ctrl;
    logic [31:0]       id_iss_imedext;
    logic [31:0]       reg_iss_dataa;
    logic [31:0]       reg_iss_datab;
    logic              iss_stall;
    logic [CTRL_W-1:0] iss_ex_ctrl;
    logic              iss_ex_writereg;
    logic              iss_ex_readmem;
    logic              iss_ex_writemem;
    logic              iss_ex_writeov;
    logic [4:0]        iss_ex_regdest;
    logic [31:0]       iss_ex_rega;
    logic [31:0]       iss_ex_regb;
    logic [31:0]       iss_ex_imedext;
    logic [31:0]       iss_pending;
    logic [31:0]       iss_stat_issued;
    logic [31:0]       iss_stat_stalls;

    int checks = 0;
    int errors = 0;

    issue_stage #(.CTRL_W(CTRL_W), .ALU_LAT(3), .LOAD_LAT(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .id_iss_addra     (id_iss_addra),
        .id_iss_addrb     (id_iss_addrb),
        .id_iss_regdest   (id_iss_regdest),
        .id_iss_selregdest(id_iss_selregdest),
        .id_iss_writereg  (id_iss_writereg),
        .id_iss_readmem   (id_iss_readmem),
        .id_iss_writemem  (id_iss_writemem),
        .id_iss_writeov   (id_iss_writeov),
        .id_iss_ctrl      (id_iss_ctrl),
        .id_iss_imedext   (id_iss_imedext),
        .reg_iss_dataa    (reg_iss_dataa),
        .reg_iss_datab    (reg_iss_datab),
        .iss_stall        (iss_stall),
        .iss_ex_ctrl      (iss_ex_ctrl),
        .iss_ex_writereg  (iss_ex_writereg),
        .iss_ex_readmem   (iss_ex_readmem),
        .iss_ex_writemem  (iss_ex_writemem),
        .iss_ex_writeov   (iss_ex_writeov),
        .iss_ex_regdest   (iss_ex_regdest),
        .iss_ex_rega      (iss_ex_rega),
        .iss_ex_regb      (iss_ex_regb),
        .iss_ex_imedext   (iss_ex_imedext),
        .iss_pending      (iss_pending),
        .iss_stat_issued  (iss_stat_issued),
        .iss_stat_stalls  (iss_stat_stalls)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit past it, away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        id_iss_addra      = 5'd0;
        id_iss_addrb      = 5'd0;
        id_iss_regdest    = 5'd0;
        id_iss_selregdest = 1'b0;
        id_iss_writereg   = 1'b0;
        id_iss_readmem    = 1'b0;
        id_iss_writemem   = 1'b0;
        id_iss_writeov    = 1'b0;
        id_iss_ctrl       = '0;
        id_iss_imedext    = 32'd0;
        reg_iss_dataa     = 32'd0;
        reg_iss_datab     = 32'd0;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".ex_ctrl"},     32'(iss_ex_ctrl), 32'd0);
        check({tag, ".ex_writereg"}, 32'(iss_ex_writereg), 32'd0);
        check({tag, ".ex_readmem"},  32'(iss_ex_readmem), 32'd0);
        check({tag, ".ex_writemem"}, 32'(iss_ex_writemem), 32'd0);
        check({tag, ".ex_regdest"},  32'(iss_ex_regdest), 32'd0);
        check({tag, ".ex_rega"},     iss_ex_rega, 32'd0);
        check({tag, ".ex_regb"},     iss_ex_regb, 32'd0);
        check({tag, ".ex_imedext"},  iss_ex_imedext, 32'd0);
    endtask

    initial begin
        // Reset held two cycles with random inputs.
        reset = 1'b0;
        id_iss_addra      = 5'($urandom);
        id_iss_addrb      = 5'($urandom);
        id_iss_regdest    = 5'($urandom);
        id_iss_selregdest = 1'b1;
        id_iss_writereg   = 1'b1;
        id_iss_readmem    = 1'($urandom);
        id_iss_writemem   = 1'($urandom);
        id_iss_writeov    = 1'b1;
        id_iss_ctrl       = CTRL_W'($urandom);
        id_iss_imedext    = $urandom;
        reg_iss_dataa     = $urandom;
        reg_iss_datab     = $urandom;
        tick();
        tick();
        check_bubble("rst");
        check("rst.ex_writeov", 32'(iss_ex_writeov), 32'd0);
        check("rst.pending", iss_pending, 32'd0);
        clear_in();
        reset = 1'b1;
        #1;
        check("rst.stall", 32'(iss_stall), 32'd0);
        check("rst.stat_issued", iss_stat_issued, 32'd0);

        // ALU RAW: producer r3, consumer reads r3 (and writes r4).
        id_iss_writereg = 1'b1;
        id_iss_regdest  = 5'd3;
        id_iss_ctrl     = 9'h1A5;
        id_iss_imedext  = 32'hFFFF_FFF0;
        reg_iss_dataa   = 32'hAAAA_0001;
        reg_iss_datab   = 32'hBBBB_0002;
        #1;
        check("alu.p.stall", 32'(iss_stall), 32'd0);
        tick();
        check("alu.p.ex_writereg", 32'(iss_ex_writereg), 32'd1);
        check("alu.p.ex_regdest", 32'(iss_ex_regdest), 32'd3);
        check("alu.p.ex_ctrl", 32'(iss_ex_ctrl), 32'h1A5);
        check("alu.p.ex_rega", iss_ex_rega, 32'hAAAA_0001);
        check("alu.p.ex_regb", iss_ex_regb, 32'hBBBB_0002);
        check("alu.p.ex_imedext", iss_ex_imedext, 32'hFFFF_FFF0);
        check("alu.p.pending", iss_pending, 32'h0000_0008);
        clear_in();
        id_iss_addra    = 5'd3;
        id_iss_writereg = 1'b1;
        id_iss_regdest  = 5'd4;
        reg_iss_dataa   = 32'h1234_5678;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("alu.c.stall", 32'(iss_stall), 32'd1);
            check("alu.c.pending3", 32'(iss_pending[3]), 32'd1);
            tick();
            check_bubble("alu.c.bubble");
        end
        check("alu.c.release", 32'(iss_stall), 32'd0);
        check("alu.c.pending", iss_pending, 32'd0);
        tick();
        check("alu.c.ex_rega", iss_ex_rega, 32'h1234_5678);
        check("alu.c.ex_regdest", 32'(iss_ex_regdest), 32'd4);
`ifdef ISSUE_STATS_EN
        check("stat.issued", iss_stat_issued, 32'd2);
        check("stat.stalls", iss_stat_stalls, 32'd3);
`else
        check("stat.issued", iss_stat_issued, 32'd0);
        check("stat.stalls", iss_stat_stalls, 32'd0);
`endif

        // Load RAW through port b (3-operand consumer).
        clear_in();
        id_iss_readmem  = 1'b1;
        id_iss_writereg = 1'b1;
        id_iss_regdest  = 5'd7;
        #1;
        check("ld.p.stall", 32'(iss_stall), 32'd0);
        tick();
        check("ld.p.ex_readmem", 32'(iss_ex_readmem), 32'd1);
        clear_in();
        id_iss_selregdest = 1'b1;
        id_iss_addrb      = 5'd7;
        reg_iss_datab     = 32'hCAFE_0007;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("ld.c.stall", 32'(iss_stall), 32'd1);
            tick();
            check("ld.c.bubble", iss_ex_regb, 32'd0);
        end
        check("ld.c.release", 32'(iss_stall), 32'd0);
        tick();
        check("ld.c.ex_regb", iss_ex_regb, 32'hCAFE_0007);

        // Load then an instruction whose rt is not a source: no stall.
        clear_in();
        id_iss_readmem  = 1'b1;
        id_iss_writereg = 1'b1;
        id_iss_regdest  = 5'd7;
        #1;
        tick();
        clear_in();
        id_iss_addrb = 5'd7;
        #1;
        check("ld.nosrc.stall", 32'(iss_stall), 32'd0);
        tick();

        // Load then a store of r7: 4 stalls (r7 counter 3 <= LOAD_LAT, no WAW).
        clear_in();
        id_iss_readmem  = 1'b1;
        id_iss_writereg = 1'b1;
        id_iss_regdest  = 5'd7;
        #1;
        check("ld.st.p.stall", 32'(iss_stall), 32'd0);
        tick();
        clear_in();
        id_iss_writemem = 1'b1;
        id_iss_addrb    = 5'd7;
        reg_iss_datab   = 32'h5707_0000;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("ld.st.stall", 32'(iss_stall), 32'd1);
            tick();
        end
        check("ld.st.release", 32'(iss_stall), 32'd0);
        tick();
        check("ld.st.ex_writemem", 32'(iss_ex_writemem), 32'd1);
        check("ld.st.ex_regb", iss_ex_regb, 32'h5707_0000);

        // r0 is never tracked.
        clear_in();
        id_iss_writereg = 1'b1;
        id_iss_regdest  = 5'd0;
        #1;
        tick();
        check("r0.pending", iss_pending, 32'd0);
        clear_in();
        id_iss_selregdest = 1'b1;
        #1;
        check("r0.stall", 32'(iss_stall), 32'd0);
        tick();

        // WAW: load r5 then ALU write r5 -> one stall, then counter reloads to 3.
        clear_in();
        id_iss_readmem  = 1'b1;
        id_iss_writereg = 1'b1;
        id_iss_regdest  = 5'd5;
        #1;
        tick();
        clear_in();
        id_iss_writereg = 1'b1;
        id_iss_writeov  = 1'b1;
        id_iss_regdest  = 5'd5;
        #1;
        check("waw.stall", 32'(iss_stall), 32'd1);
        tick();
        check("waw.bubble", 32'(iss_ex_writeov), 32'd0);
        check("waw.release", 32'(iss_stall), 32'd0);
        tick();
        check("waw.ex_writeov", 32'(iss_ex_writeov), 32'd1);
        clear_in();
        id_iss_addra = 5'd5;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("waw.reload.stall", 32'(iss_stall), 32'd1);
            tick();
        end
        check("waw.reload.release", 32'(iss_stall), 32'd0);
        tick();

        // Reset in the middle of an ALU RAW stall.
        clear_in();
        id_iss_writereg = 1'b1;
        id_iss_regdest  = 5'd3;
        #1;
        tick();
        clear_in();
        id_iss_addra  = 5'd3;
        reg_iss_dataa = 32'h0BAD_F00D;
        #1;
        check("mid.stall", 32'(iss_stall), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        check("mid.pending", iss_pending, 32'd0);
        check("mid.stall_drop", 32'(iss_stall), 32'd0);
        check_bubble("mid.rst");
        check("mid.stat_issued", iss_stat_issued, 32'd0);
        check("mid.stat_stalls", iss_stat_stalls, 32'd0);
        reset = 1'b1;
        tick();
        check("mid.ex_rega", iss_ex_rega, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Pipeline stage between decode and execute.
- Holds a per-register scoreboard of in-flight writes and stalls decode (iss_stall) on RAW and WAW hazards.
- Captures register-file read data and forwards the decoded control bundle to execute; inserts a bubble on every stalled cycle.

Parameters:
CTRL_W, 9, width of opaque control bundle {selalushift, selimregb, aluop[2:0], unsig, shiftop[1:0], selwsource}
ALU_LAT, 3, cycles from issue until a non-load result is in the register file (1..7)
LOAD_LAT, 4, same for loads (readmem=1); LOAD_LAT >= ALU_LAT, max 7

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
id_iss_addra  in  5  rs address of instruction in decode
id_iss_addrb  in  5  rt address
id_iss_regdest  in  5  destination register
id_iss_selregdest  in  1  3-operand instruction (rt is a source)
id_iss_writereg  in  1  instruction writes regdest
id_iss_readmem  in  1  load
id_iss_writemem  in  1  store (rt is a source)
id_iss_writeov  in  1  overflow-write enable
id_iss_ctrl  in  CTRL_W  control bundle, forwarded unchanged
id_iss_imedext  in  32  sign-extended immediate
reg_iss_dataa  in  32  register file read data, port a (combinational read of addra)
reg_iss_datab  in  32  register file read data, port b
iss_stall  out  1  combinational; decode holds its outputs while high
iss_ex_ctrl  out  CTRL_W  registered control bundle
iss_ex_writereg / iss_ex_readmem / iss_ex_writemem / iss_ex_writeov  out  1 each  registered, zero in bubbles
iss_ex_regdest  out  5  registered destination
iss_ex_rega / iss_ex_regb / iss_ex_imedext  out  32 each  registered operands
iss_pending  out  32  scoreboard busy bitmap (bit i = counter[i] != 0)

Behaviour:
- Scoreboard: 32 x 3-bit down-counters; counter[i] = cycles until register i holds its new value. Writeback writes at the edge where the counter goes 1->0; the value is readable in the 0 cycle. Counter 0 is hardwired to 0.
- Each edge, every nonzero counter decrements by 1. The entry being loaded takes the new value instead of decrementing.
- lat = readmem ? LOAD_LAT : ALU_LAT.
- hz_a = addra != 0 and counter[addra] != 0.
- hz_b = (selregdest or writemem) and addrb != 0 and counter[addrb] != 0.
- hz_w = writereg and regdest != 0 and counter[regdest] > lat. This is the WAW rule; an equal counter is allowed.
- iss_stall = hz_a or hz_b or hz_w. Purely combinational from inputs and counters; no other inputs gate it.
- Issue (iss_stall=0), at the edge:
  - All iss_ex_* outputs load from their inputs.
  - rega/regb load reg_iss_dataa/datab.
  - If writereg and regdest != 0, counter[regdest] <= lat.
- Stall (iss_stall=1), at the edge:
  - A bubble is issued: every iss_ex_* output loads 0.
  - No counter is loaded; decrements continue.
- Latency: an issued instruction appears at execute 1 cycle later. A dependent instruction following an ALU producer stalls exactly ALU_LAT cycles; after a load it stalls LOAD_LAT cycles.
- Reset (reset=0 at edge): all counters and all outputs clear to 0, including mid-stall; iss_stall then evaluates against the cleared scoreboard. The stats counters also clear.
- Reads and writes of r0 never stall and never mark pending.

Optional Feature:
ISSUE_STATS_EN
- Defined: adds outputs iss_stat_issued[31:0] and iss_stat_stalls[31:0].
  - iss_stat_issued increments on each issue edge with writereg|readmem|writemem|writeov nonzero.
  - iss_stat_stalls increments on each stall edge.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports exist and are tied to 0; no counter logic.

Test Plan:
- Reset: hold reset=0 two cycles with random inputs -> all iss_ex_* = 0, iss_pending = 0, iss_stall = 0 after release with addra=addrb=0.
- ALU RAW: issue writereg=1, regdest=3; next instr addra=3 -> iss_stall=1 for exactly 3 cycles (iss_pending[3]=1), issues on the 4th with rega = reg_iss_dataa; ex outputs zero during stalls.
- Load RAW: readmem=1, regdest=7; next instr selregdest=1, addrb=7 -> 4 stall cycles. Repeat with selregdest=0, writemem=0 -> 0 stalls; with writemem=1 -> 4 stalls.
- r0: writereg=1, regdest=0, then addra=0 -> iss_pending=0, no stall.
- WAW: load to r5, then ALU writing r5 with no sources -> 1 stall cycle; counter[5] reloads to 3 on issue.
- Reset mid-stall during test 2 -> iss_pending=0, stall drops next cycle. With ISSUE_STATS_EN, sequence 2 yields issued=2, stalls=3.
